issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter IQ_ENTRY, default 8, queue depth in entries (power of two, >=2).
REQ-002 Parameter PREG_W, default $clog2(NUM_PHYS_REG), physical register tag width.
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 renamed_i  input  RENAMED_INSTRUCTION_WIDTH  renamed_instruction_t from rename stage.
REQ-006 renamed_v_i  input  1  renamed_i valid.
REQ-007 issue_rename_ready_o  output  1  queue can accept an instruction this cycle.
REQ-008 wb_v_i  input  1  writeback broadcast valid.
REQ-009 wb_preg_i  input  PREG_W  physical register written back.
REQ-010 issued_o  output  RENAMED_INSTRUCTION_WIDTH  instruction sent to execute, renamed_instruction_t, unmodified.
REQ-011 issued_v_o  output  1  issued_o valid.
REQ-012 exec_ready_i  input  1  execute accepts issued_o.
REQ-013 flush_i  input  1  mispredict rollback (commit valid AND mispredict).
REQ-014 count_o  output  $clog2(IQ_ENTRY)+1  occupied entries, debug/perf.

Function
REQ-015 Sources: src1 = source_1 always; src2 = source2_imm[PREG_W-1:0] only when imm==0, else src2 treated ready.
REQ-016 Scoreboard: NUM_PHYS_REG busy bits; instruction enqueued with w_v==1 sets busy[dest_id]; wb_v_i clears busy[wb_preg_i].
REQ-017 Same-cycle scoreboard set and clear on same tag: set wins.
REQ-018 Entry = instruction + rdy1 + rdy2; at enqueue rdyN = !busy[srcN] OR (wb_v_i AND wb_preg_i==srcN) (same-cycle wakeup bypass).
REQ-019 Each cycle wb_v_i sets rdyN of every valid entry whose srcN==wb_preg_i.
REQ-020 Queue is age-ordered and compacting: slot 0 oldest; removal of slot k shifts slots k+1..count-1 down by one in the same cycle.
REQ-021 Enqueue when renamed_v_i AND issue_rename_ready_o; new entry written at slot (count - removed) so order holds on simultaneous enqueue and removal.
REQ-022 issue_rename_ready_o = (count < IQ_ENTRY) AND !flush_i; no same-cycle credit from a removal.
REQ-023 Output register: one-entry register driving issued_o/issued_v_o; it may load when empty or when issued_v_o AND exec_ready_i.
REQ-024 Select: when output register may load, lowest-index entry with rdy1 AND rdy2 (using pre-wakeup rdy bits of this cycle) is removed and loaded; no ready entry -> issued_v_o becomes 0 if consumed.
REQ-025 Issue latency: instruction enqueued ready at cycle N is at earliest issued_v_o=1 at cycle N+2 (queue write N+1, select to output N+2 visible).
REQ-026 issued_o holds stable while issued_v_o=1 AND exec_ready_i=0.
REQ-027 Full: count==IQ_ENTRY -> ready low; renamed_v_i ignored; contents unchanged except wakeup/select.
REQ-028 Empty: count==0 -> no select; output register drains normally.
REQ-029 flush_i: next cycle count=0, all entries invalid, issued_v_o=0, all busy bits cleared; flush overrides enqueue, select and wakeup in that cycle.
REQ-030 count arithmetic: count_next = count + enq - deq, never exceeds IQ_ENTRY nor underflows.

Reset
REQ-031 On reset_i: count_o=0, issued_v_o=0, issued_o=0, issue_rename_ready_o=1 the cycle after, all busy bits 0, all entries invalid.
REQ-032 reset_i mid-operation discards all entries and the output register in one cycle; reset overrides flush, enqueue and wakeup.

Verification
REQ-033 After reset, enqueue ADD src1=p3,src2=p4,dest=p40, exec_ready_i=1 -> issued_v_o=1 two cycles later with dest_id=40, count_o returns to 0.
REQ-034 Enqueue A dest=p40, then B src1=p40; hold wb_v_i=0 -> B not issued; wb_v_i=1,wb_preg_i=40 -> B issued within 2 cycles.
REQ-035 Fill 8 non-ready entries -> issue_rename_ready_o=0, count_o=8; 9th renamed_v_i dropped; one wakeup releases oldest, ready returns next cycle.
REQ-036 Entries 0 (not ready) and 1,2 (ready) -> issue order 1 then 2; entry 0 issues after its wakeup; simultaneous enqueue lands behind survivors.
REQ-037 exec_ready_i=0 for 5 cycles with issued_v_o=1 -> issued_o stable, no entry removed.
REQ-038 flush_i=1 with count_o=5, issued_v_o=1, renamed_v_i=1 -> next cycle count_o=0, issued_v_o=0, new instruction not enqueued, busy bits all 0.

Source files
------------

// File: rtl/issue_queue_if.sv
// issue_queue_if: rename, writeback, issue and flush signals of the issue queue.
// Instruction layout (lsb first): source2_imm[15:0], source_1, dest_id, w_v, imm, opcode[7:0].
interface issue_queue_if #(
    parameter int PREG_W = 6,
    parameter int INS_W  = 26 + 2 * PREG_W,
    parameter int CNT_W  = 4
);
    logic [INS_W-1:0]  renamed_i;
    logic              renamed_v_i;
    logic              issue_rename_ready_o;
    logic              wb_v_i;
    logic [PREG_W-1:0] wb_preg_i;
    logic [INS_W-1:0]  issued_o;
    logic              issued_v_o;
    logic              exec_ready_i;
    logic              flush_i;
    logic [CNT_W-1:0]  count_o;
    modport slave (
        input  renamed_i, renamed_v_i, wb_v_i, wb_preg_i, exec_ready_i, flush_i,
        output issue_rename_ready_o, issued_o, issued_v_o, count_o
    );
    modport master (
        output renamed_i, renamed_v_i, wb_v_i, wb_preg_i, exec_ready_i, flush_i,
        input  issue_rename_ready_o, issued_o, issued_v_o, count_o
    );
endinterface

// File: rtl/issue_queue.sv
// issue_queue: age-ordered compacting issue queue with a busy-bit scoreboard,
// writeback wakeup and a one-entry output register toward execute.
module issue_queue #(
    parameter int IQ_ENTRY     = 8,
    parameter int NUM_PHYS_REG = 64,
    parameter int PREG_W       = $clog2(NUM_PHYS_REG)
) (
    input logic         clk_i,
    input logic         reset_i,
    issue_queue_if.slave bus
);
    localparam int INS_W = 26 + 2 * PREG_W;
    localparam int CNT_W = $clog2(IQ_ENTRY) + 1;
    localparam int S1    = 16;
    localparam int DST   = 16 + PREG_W;
    localparam int WV    = 16 + 2 * PREG_W;
    localparam int IMM   = WV + 1;

    logic [INS_W-1:0]        r_q [IQ_ENTRY];
    logic [IQ_ENTRY-1:0]     r_rdy1, r_rdy2;
    logic [CNT_W-1:0]        r_count;
    logic [NUM_PHYS_REG-1:0] r_busy;
    logic [INS_W-1:0]        r_out;
    logic                    r_out_v;

    logic [INS_W-1:0]        w_q [IQ_ENTRY];
    logic [IQ_ENTRY-1:0]     w_rdy1, w_rdy2, w_valid, w_hit, w_ge;
    logic [INS_W-1:0]        w_pick;
    logic                    w_found, w_load, w_enq, w_deq, w_ready;
    logic [CNT_W-1:0]        w_wr;
    logic [PREG_W-1:0]       w_new_s1, w_new_s2;
    logic                    w_new_r1, w_new_r2;
    logic [NUM_PHYS_REG-1:0] w_busy_n;

    assign w_ready  = (r_count < CNT_W'(IQ_ENTRY)) && !bus.flush_i;
    assign w_enq    = bus.renamed_v_i && w_ready;
    assign w_load   = !r_out_v || bus.exec_ready_i;
    assign w_deq    = w_load && w_found;
    assign w_wr     = r_count - CNT_W'(w_deq);
    assign w_hit    = w_valid & r_rdy1 & r_rdy2;
    assign w_new_s1 = bus.renamed_i[S1 +: PREG_W];
    assign w_new_s2 = bus.renamed_i[PREG_W-1:0];
    // A writeback in the enqueue cycle counts as already done for the new entry.
    assign w_new_r1 = !r_busy[w_new_s1] || (bus.wb_v_i && bus.wb_preg_i == w_new_s1);
    assign w_new_r2 = bus.renamed_i[IMM] || !r_busy[w_new_s2] ||
                      (bus.wb_v_i && bus.wb_preg_i == w_new_s2);

    // Oldest ready entry wins; w_ge marks the selected slot and everything above it.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_ge    = '0;
        for (int i = 0; i < IQ_ENTRY; i++) begin
            w_pick  = (w_hit[i] && !w_found) ? r_q[i] : w_pick;
            w_found = w_found | w_hit[i];
            w_ge[i] = w_found;
        end
    end

    for (genvar k = 0; k < IQ_ENTRY; k++) begin : g_slot
        logic [INS_W-1:0] w_src;
        logic             w_r1, w_r2, w_wake1, w_wake2, w_put;
        assign w_valid[k] = r_count > CNT_W'(k);
        if (k < IQ_ENTRY - 1) begin : g_sh
            assign w_src = (w_deq && w_ge[k]) ? r_q[k+1]    : r_q[k];
            assign w_r1  = (w_deq && w_ge[k]) ? r_rdy1[k+1] : r_rdy1[k];
            assign w_r2  = (w_deq && w_ge[k]) ? r_rdy2[k+1] : r_rdy2[k];
        end else begin : g_top
            assign w_src = r_q[k];
            assign w_r1  = r_rdy1[k];
            assign w_r2  = r_rdy2[k];
        end
        assign w_wake1   = bus.wb_v_i && w_src[S1 +: PREG_W] == bus.wb_preg_i;
        assign w_wake2   = bus.wb_v_i && w_src[PREG_W-1:0] == bus.wb_preg_i;
        assign w_put     = w_enq && w_wr == CNT_W'(k);
        assign w_q[k]    = w_put ? bus.renamed_i : w_src;
        assign w_rdy1[k] = w_put ? w_new_r1 : (w_r1 || w_wake1);
        assign w_rdy2[k] = w_put ? w_new_r2 : (w_r2 || w_wake2);
    end

    // Set is applied after clear so a same-tag set wins.
    assign w_busy_n = (r_busy & ~(bus.wb_v_i ? (NUM_PHYS_REG'(1) << bus.wb_preg_i) : '0)) |
                      ((w_enq && bus.renamed_i[WV]) ?
                       (NUM_PHYS_REG'(1) << bus.renamed_i[DST +: PREG_W]) : '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
            r_out_v <= 1'b0;
            r_out   <= '0;
            r_busy  <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
        end else if (bus.flush_i) begin
            r_count <= '0;
            r_out_v <= 1'b0;
            r_busy  <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            r_busy  <= w_busy_n;
            r_q     <= w_q;
            r_rdy1  <= w_rdy1;
            r_rdy2  <= w_rdy2;
            if (w_load) begin
                r_out_v <= w_found;
                r_out   <= w_found ? w_pick : r_out;
            end
        end
    end

    assign bus.issue_rename_ready_o = w_ready;
    assign bus.issued_o             = r_out;
    assign bus.issued_v_o           = r_out_v;
    assign bus.count_o              = r_count;
endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed stimulus checked each cycle against a queue-based
// model of the issue queue, plus hand-computed expectations per scenario.
module tb_issue_queue;
    localparam int N  = 8;
    localparam int PW = 6;
    localparam int IW = 26 + 2 * PW;
    localparam int CW = 4;

    typedef struct {
        logic [IW-1:0] ins;
        bit            r1;
        bit            r2;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ent_t          m_q[$];
    bit            m_busy[64];
    bit            m_ov;
    logic [IW-1:0] m_out;

    issue_queue_if #(.PREG_W(PW), .INS_W(IW), .CNT_W(CW)) bus();
    issue_queue #(.IQ_ENTRY(N), .NUM_PHYS_REG(64)) dut (
        .clk_i(clk), .reset_i(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(int dest, int s1, int s2, bit imm, bit wv);
        return {8'h01, imm, wv, 6'(dest), 6'(s1), 16'(s2)};
    endfunction

    function automatic int dst(logic [IW-1:0] x);
        return int'(x[22 +: 6]);
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: select oldest ready, wake survivors, append new entry, then scoreboard.
    always @(posedge clk) begin : model
        int  sel;
        bit  enq;
        ent_t e;
        logic [IW-1:0] x;
        if (rst || bus.flush_i) begin
            m_q.delete();
            m_ov = 1'b0;
            if (rst) m_out = '0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            x   = bus.renamed_i;
            enq = bus.renamed_v_i && m_q.size() < N;
            sel = -1;
            foreach (m_q[i]) if (sel < 0 && m_q[i].r1 && m_q[i].r2) sel = i;
            if (!m_ov || bus.exec_ready_i) begin
                if (sel >= 0) begin
                    m_out = m_q[sel].ins;
                    m_ov  = 1'b1;
                    m_q.delete(sel);
                end else m_ov = 1'b0;
            end
            if (bus.wb_v_i) foreach (m_q[i]) begin
                if (m_q[i].ins[21:16] == bus.wb_preg_i) m_q[i].r1 = 1'b1;
                if (!m_q[i].ins[29] && m_q[i].ins[5:0] == bus.wb_preg_i) m_q[i].r2 = 1'b1;
            end
            if (enq) begin
                e.ins = x;
                e.r1  = !m_busy[x[21:16]] || (bus.wb_v_i && bus.wb_preg_i == x[21:16]);
                e.r2  = x[29] || !m_busy[x[5:0]] || (bus.wb_v_i && bus.wb_preg_i == x[5:0]);
                m_q.push_back(e);
            end
            if (bus.wb_v_i) m_busy[bus.wb_preg_i] = 1'b0;
            if (enq && x[28]) m_busy[x[27:22]] = 1'b1;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("count", 64'(bus.count_o), 64'(m_q.size()));
        check("issued_v", 64'(bus.issued_v_o), 64'(m_ov));
        if (m_ov) check("issued", 64'(bus.issued_o), 64'(m_out));
        check("ready", 64'(bus.issue_rename_ready_o), 64'(m_q.size() < N && !bus.flush_i));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(logic [IW-1:0] x);
        bus.renamed_v_i = 1'b1;
        bus.renamed_i   = x;
        step();
        bus.renamed_v_i = 1'b0;
    endtask

    task automatic wb(int p);
        bus.wb_v_i    = 1'b1;
        bus.wb_preg_i = 6'(p);
        step();
        bus.wb_v_i = 1'b0;
    endtask

    task automatic chk_out(string nm, int d);
        check({nm, "_v"}, 64'(bus.issued_v_o), 64'd1);
        check({nm, "_dest"}, 64'(dst(bus.issued_o)), 64'(d));
    endtask

    initial begin
        bus.renamed_i = '0; bus.renamed_v_i = 1'b0; bus.wb_v_i = 1'b0;
        bus.wb_preg_i = '0; bus.exec_ready_i = 1'b1; bus.flush_i = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_issued_v", 64'(bus.issued_v_o), 64'd0);
        check("rst_issued", 64'(bus.issued_o), 64'd0);
        check("rst_ready", 64'(bus.issue_rename_ready_o), 64'd1);
        // Single ready instruction: visible two edges after it is presented.
        enq(mk(40, 3, 4, 0, 1));
        check("add_count", 64'(bus.count_o), 64'd1);
        check("add_early", 64'(bus.issued_v_o), 64'd0);
        step();
        chk_out("add", 40);
        check("add_drain", 64'(bus.count_o), 64'd0);
        step();
        check("add_gone", 64'(bus.issued_v_o), 64'd0);
        // Dependent waits on p40 until its writeback.
        enq(mk(41, 40, 0, 1, 0));
        repeat (4) step();
        check("dep_wait", 64'(bus.issued_v_o), 64'd0);
        check("dep_count", 64'(bus.count_o), 64'd1);
        wb(40);
        check("dep_wake_edge", 64'(bus.issued_v_o), 64'd0);
        step();
        chk_out("dep", 41);
        step();
        // Fill with entries waiting on p50.
        enq(mk(50, 1, 0, 1, 1));
        for (int i = 0; i < N; i++) enq(mk(60 + i, 50, 0, 1, 0));
        check("full_count", 64'(bus.count_o), 64'd8);
        check("full_ready", 64'(bus.issue_rename_ready_o), 64'd0);
        enq(mk(70, 1, 0, 1, 0));
        check("full_drop", 64'(bus.count_o), 64'd8);
        wb(50);
        check("full_wake", 64'(bus.count_o), 64'd8);
        step();
        check("full_release", 64'(bus.count_o), 64'd7);
        check("full_ready_back", 64'(bus.issue_rename_ready_o), 64'd1);
        chk_out("full_oldest", 60);
        repeat (8) step();
        check("full_empty", 64'(bus.count_o), 64'd0);
        // Ordering: blocked oldest, younger ready ones bypass it.
        enq(mk(20, 1, 0, 1, 1));
        enq(mk(21, 20, 0, 1, 0));
        chk_out("ord_prod", 20);
        enq(mk(22, 1, 0, 1, 0));
        check("ord_none", 64'(bus.issued_v_o), 64'd0);
        enq(mk(23, 1, 0, 1, 0));
        chk_out("ord_first", 22);
        bus.wb_v_i = 1'b1;
        bus.wb_preg_i = 6'd20;
        enq(mk(24, 2, 0, 1, 0));
        bus.wb_v_i = 1'b0;
        chk_out("ord_second", 23);
        check("ord_count", 64'(bus.count_o), 64'd2);
        step();
        chk_out("ord_woken", 21);
        step();
        chk_out("ord_behind", 24);
        check("ord_empty", 64'(bus.count_o), 64'd0);
        step();
        // Back-pressure holds the output register.
        bus.exec_ready_i = 1'b0;
        enq(mk(30, 1, 0, 1, 0));
        enq(mk(31, 1, 0, 1, 0));
        chk_out("bp_load", 30);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("bp_hold", 30);
            check("bp_count", 64'(bus.count_o), 64'd1);
        end
        bus.exec_ready_i = 1'b1;
        step();
        chk_out("bp_next", 31);
        check("bp_empty", 64'(bus.count_o), 64'd0);
        step();
        // Flush with five queued, output valid and a concurrent enqueue.
        bus.exec_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) enq(mk(10 + i, 1, 0, 1, 1));
        check("fl_count", 64'(bus.count_o), 64'd5);
        check("fl_out_v", 64'(bus.issued_v_o), 64'd1);
        bus.flush_i = 1'b1;
        bus.renamed_v_i = 1'b1;
        bus.renamed_i = mk(16, 1, 0, 1, 1);
        #1;
        check("fl_ready_low", 64'(bus.issue_rename_ready_o), 64'd0);
        step();
        bus.flush_i = 1'b0;
        bus.renamed_v_i = 1'b0;
        #1;
        check("fl_count0", 64'(bus.count_o), 64'd0);
        check("fl_out_v0", 64'(bus.issued_v_o), 64'd0);
        check("fl_ready", 64'(bus.issue_rename_ready_o), 64'd1);
        bus.exec_ready_i = 1'b1;
        enq(mk(17, 10, 11, 0, 0));
        step();
        chk_out("fl_busy_clear", 17);
        // Reset mid-operation.
        enq(mk(18, 1, 0, 1, 0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_count", 64'(bus.count_o), 64'd0);
        check("mid_rst_v", 64'(bus.issued_v_o), 64'd0);
        check("mid_rst_out", 64'(bus.issued_o), 64'd0);
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
